bin2bcd_display_feeder: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the 7-segment display driver.
- Converts an unsigned binary value into WIDTH_NIBBLES packed BCD digits, ready for the driver's data input.
- Generates a digit-enable mask with optional leading-zero blanking, ready for the driver's digit_enable input.
- Saturates and flags values that do not fit in the display.

---
 rtl/bin2bcd_display_feeder.sv | 118 +++++++++++
 tb/tb_bin2bcd_display_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_display_feeder.sv
// rtl/bin2bcd_display_feeder.sv - sequential shift-and-add-3 binary-to-BCD converter feeding a 7-segment driver
module bin2bcd_display_feeder #(
    parameter int INPUT_WIDTH   = 20,
    parameter int WIDTH_NIBBLES = 6,
    parameter bit LZ_BLANK      = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INPUT_WIDTH-1:0]     value,
    input  logic                       start,
    output logic                       busy,
    output logic                       valid,
    output logic [WIDTH_NIBBLES*4-1:0] bcd,
    output logic [WIDTH_NIBBLES-1:0]   digit_enable,
    output logic                       overflow
);

    localparam int BW = 4 * WIDTH_NIBBLES;
    localparam int CW = $clog2(INPUT_WIDTH + 1);

    function automatic logic [63:0] dec_max();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < WIDTH_NIBBLES; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0]              DEC_MAX = dec_max();
    localparam logic [WIDTH_NIBBLES-1:0] EN_RST  = LZ_BLANK ? WIDTH_NIBBLES'(1) : {WIDTH_NIBBLES{1'b1}};

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                   state_q;
    logic [INPUT_WIDTH-1:0]   shift_q;
    logic [BW-1:0]            acc_q;
    logic [CW-1:0]            cnt_q;
    logic                     ovf_q;
    logic [BW-1:0]            bcd_q;
    logic [WIDTH_NIBBLES-1:0] en_q;
    logic                     overflow_q;
    logic                     valid_q;

    logic [BW-1:0]            adj;
    logic [BW-1:0]            acc_d;
    logic [BW-1:0]            bcd_d;
    logic [WIDTH_NIBBLES-1:0] en_d;
    logic                     seen;
    logic                     ovf_d;

    // 64-bit compare keeps the decimal limit exact for any supported width
    assign ovf_d = 64'(value) > DEC_MAX;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < WIDTH_NIBBLES; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_d = {adj[BW-2:0], shift_q[INPUT_WIDTH-1]};
        bcd_d = ovf_q ? {WIDTH_NIBBLES{4'h9}} : acc_q;
        en_d  = {WIDTH_NIBBLES{1'b1}};
        seen  = 1'b0;
        if (LZ_BLANK) begin
            for (int i = WIDTH_NIBBLES - 1; i >= 0; i--) begin
                seen    = seen | (bcd_d[4*i +: 4] != 4'd0);
                en_d[i] = seen;
            end
            en_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            en_q       <= EN_RST;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= value;
                        ovf_q   <= ovf_d;
                        acc_q   <= '0;
                        cnt_q   <= CW'(INPUT_WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= LOAD;
                end
                LOAD: begin
                    bcd_q      <= bcd_d;
                    en_q       <= en_d;
                    overflow_q <= ovf_q;
                    valid_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign valid        = valid_q;
    assign bcd          = bcd_q;
    assign digit_enable = en_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
// tb/tb_bin2bcd_display_feeder.sv - scoreboard bench for bin2bcd_display_feeder
module tb_bin2bcd_display_feeder;

    localparam int IW = 20;
    localparam int N  = 6;
    localparam bit LZ = 1'b1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] value = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          valid;
    logic [4*N-1:0] bcd;
    logic [N-1:0]  digit_enable;
    logic          overflow;

    bin2bcd_display_feeder #(.INPUT_WIDTH(IW), .WIDTH_NIBBLES(N), .LZ_BLANK(LZ)) dut (
        .clk(clk), .reset(reset), .value(value), .start(start), .busy(busy),
        .valid(valid), .bcd(bcd), .digit_enable(digit_enable), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] bcd;
        logic [N-1:0]   en;
        logic           ovf;
        int             due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   next_free = 0;
    int   checks = 0;
    int   errors = 0;

    logic [4*N-1:0] last_bcd;
    logic [N-1:0]   last_en;
    logic           last_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, mask from the highest non-zero digit
    function automatic exp_t model(input int unsigned v, input int due);
        exp_t        e;
        longint unsigned x, p, maxv;
        int          top, d;
        maxv = 1;
        for (int i = 0; i < N; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        x     = longint'(v);
        e.ovf = (x > maxv);
        e.bcd = '0;
        top   = 0;
        p     = 1;
        for (int i = 0; i < N; i++) begin
            d = e.ovf ? 9 : int'((x / p) % 10);
            e.bcd[4*i +: 4] = 4'(d);
            if (d != 0) top = i;
            p = p * 10;
        end
        e.en  = LZ ? N'((1 << (top + 1)) - 1) : {N{1'b1}};
        e.due = due;
        return e;
    endfunction

    task automatic drive(input int unsigned v, input logic s);
        @(posedge clk);
        #2;
        value = IW'(v);
        start = s;
        if (s && !reset && cyc >= next_free) begin
            q.push_back(model(v, cyc + 22));
            next_free = cyc + 22;
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !valid; i++) drive(0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        start = 1'b0;
        q.delete();
        next_free = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    function automatic int unsigned pick();
        case ($urandom_range(0, 5))
            0:       return $urandom_range(0, 99);
            1:       return $urandom_range(999990, 1000010);
            2:       return 32'd1048575;
            default: return $urandom_range(0, (1 << IW) - 1);
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_valid", 64'(valid), 64'd0);
            chk("rst_bcd", 64'(bcd), 64'd0);
            chk("rst_en", 64'(digit_enable), LZ ? 64'd1 : 64'(N'('1)));
            chk("rst_ovf", 64'(overflow), 64'd0);
            last_bcd = '0;
            last_en  = LZ ? N'(1) : {N{1'b1}};
            last_ovf = 1'b0;
        end else if (valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'(valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                chk("bcd", 64'(bcd), 64'(e.bcd));
                chk("digit_enable", 64'(digit_enable), 64'(e.en));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("busy_in_valid", 64'(busy), 64'd0);
                last_bcd = e.bcd;
                last_en  = e.en;
                last_ovf = e.ovf;
            end
        end else begin
            if (q.size() > 0 && cyc > q[0].due) begin
                chk("valid_timeout", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            chk("hold_bcd", 64'(bcd), 64'(last_bcd));
            chk("hold_en", 64'(digit_enable), 64'(last_en));
            chk("hold_ovf", 64'(overflow), 64'(last_ovf));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (10) drive(0, 1'b0);

        drive(123456, 1'b1);
        drive(0, 1'b0);
        wait_valid();

        drive(0, 1'b1);
        drive(0, 1'b0);
        wait_valid();
        drive(705, 1'b1);
        drive(0, 1'b0);
        wait_valid();

        foreach (q[i]) ;
        drive(999999, 1'b1);
        drive(0, 1'b0);
        wait_valid();
        drive(1000000, 1'b1);
        drive(0, 1'b0);
        wait_valid();
        drive(1048575, 1'b1);
        drive(0, 1'b0);
        wait_valid();
        repeat (2) drive(0, 1'b0);

        drive(42, 1'b1);
        repeat (3) drive(77, 1'b0);
        drive(77, 1'b1);
        repeat (14) drive(77, 1'b0);
        drive(77, 1'b1);
        drive(77, 1'b1);
        drive(77, 1'b0);
        wait_valid();
        repeat (2) drive(0, 1'b0);

        drive(31337, 1'b1);
        repeat (8) drive(0, 1'b0);
        pulse_reset();
        repeat (25) drive(0, 1'b0);
        drive(9, 1'b1);
        drive(0, 1'b0);
        wait_valid();
        repeat (2) drive(0, 1'b0);

        repeat (700) drive(pick(), $urandom_range(0, 3) == 0);
        repeat (30) drive(0, 1'b0);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
